eth_recv: RTL and testbench
===========================

# eth_recv

Receive-side counterpart of `eth_send`: consumes the 10G MAC's 64-bit AXI-Stream RX output (`m_axis_rx_*`) in the `clk156` domain. It parses Ethernet/IPv4/UDP timestamp probe frames, extracts the sequence number and transmit timestamp, and reports one-way/loopback latency against a shared free-running timestamp. It also keeps frame statistics for LED/debug use.

## Interface
Parameters:
- `UDP_PORT`, 16'h0D80: required UDP destination port.
- `MAGIC`, 16'h5453: required payload magic ("TS").

Ports:
- `clk156`  in  1  MAC core clock; the only clock.
- `reset`  in  1  synchronous reset, active-high.
- `ts_now`  in  32  free-running timestamp, same counter `eth_send` stamps from.
- `m_axis_rx_tvalid`  in  1  MAC RX beat valid. There is no tready; the block always accepts.
- `m_axis_rx_tdata`  in  64  beat data. tdata[7:0] is the first wire byte.
- `m_axis_rx_tkeep`  in  8  byte enables; only meaningful on the tlast beat.
- `m_axis_rx_tlast`  in  1  last beat of frame.
- `m_axis_rx_tuser`  in  1  sampled on the tlast beat: 1 = good FCS, 0 = bad frame.
- `lat_valid`  out  1  one-cycle pulse, result valid.
- `lat`  out  32  latency = rx_ts − tx_ts, modulo 2^32.
- `lat_seq`  out  32  sequence number of the measured frame.
- `cnt_frames`  out  32  count of all frames ended (tlast beats).
- `cnt_match`  out  32  count of valid probe frames.
- `cnt_err`  out  32  count of frames with tuser=0 at tlast.

## Operation
Frame byte offsets, big-endian fields:
- Ethertype at bytes 12–13 = 0x0800.
- Byte 14 = 0x45.
- IP protocol at byte 23 = 0x11.
- UDP destination port at bytes 36–37 = `UDP_PORT`.
- Magic at bytes 42–43 = `MAGIC`.
- seq at bytes 44–47.
- tx_ts at bytes 48–51.

These fields land in beats 1, 1, 2, 4, 5, 5 and 6 respectively.

Beat handling:
- Beat counter `beat`, 3 bits, saturates at 7.
- `ok` flag: set at SOF, cleared by any failing field check.
- rx_ts is latched from `ts_now` on the SOF beat.

FSM (registered, state enum in the package):
- `S_SOF`: waits for a tvalid beat.
  - Latch rx_ts, set beat=1, ok=1.
  - tvalid&tlast → frame ends immediately (short frame), stay in `S_SOF`.
  - Otherwise → `S_HDR`.
- `S_HDR`: on each tvalid beat, check that beat's fields and increment beat.
  - Beat 6 without tlast → `S_TAIL`.
  - tlast on any beat ≤6 ends the frame.
    - If that beat is 6 and tkeep[3:0]=4'hF, the frame is eligible.
    - Otherwise the frame is short and not matched.
    - Either way → `S_SOF`.
- `S_TAIL`: ignore data; tvalid&tlast ends the frame → `S_SOF`.

Frame end (every tlast beat):
- `cnt_frames`++.
- If tuser=0: `cnt_err`++.
- Else if eligible & ok: `cnt_match`++ and emit result.

Other rules:
- tvalid=0 cycles inside a frame: hold all state.
- Counters wrap at 2^32.

## Timing
- Reset values:
  - FSM = `S_SOF`.
  - `lat_valid`=0.
  - `lat`, `lat_seq`, all counters = 0.
- `lat_valid` pulses exactly 1 cycle, the cycle after the tlast beat is sampled.
- `lat` and `lat_seq` hold their values until the next result.
- Counters update in the same cycle as `lat_valid` (tlast beat + 1).
- Back-to-back frames: a SOF beat may follow a tlast beat with zero idle cycles. Results for consecutive frames are then 1+ cycles apart and none are lost.
- Latency wrap: rx_ts < tx_ts yields the modular difference, with no saturation.
- Reset mid-frame: the FSM returns to `S_SOF` and no result or counter update occurs for that frame. The remaining beats are parsed as a new frame; they fail checks or end as a short frame and are counted in `cnt_frames` only.
- No combinational path from any input to any output.

## Structure
- `eth_ts_pkg` (shared with `eth_send`) holds:
  - UDP_PORT/MAGIC defaults.
  - Byte-offset localparams.
  - Ethertype/protocol constants.
  - `rx_state_t` enum.
  - Probe field widths.
- Sub-module `eth_rx_stats`: the three 32-bit counters with increment strobes and synchronous reset.
- Parsing, the FSM and the latency subtractor stay in `eth_recv`.

## Test plan
- Valid 64-byte probe: seq=0x00000005, tx_ts=0x100, `ts_now`=0x180 at SOF, tuser=1. Expect `lat_valid` for 1 cycle at tlast+1, `lat`=0x80, `lat_seq`=5, `cnt_match`=1, `cnt_frames`=1.
- Same probe with tuser=0 at tlast → no `lat_valid`, `cnt_err`=1, `cnt_frames`=1, `cnt_match`=0.
- Wrong UDP dport 0x0D81, then ethertype 0x86DD, then magic 0x0000 → `cnt_frames`=3, `cnt_match`=0, no `lat_valid`.
- Two probes back-to-back with zero idle, plus random tvalid=0 gaps inside frames → two results with correct seq values in order; `cnt_match`=2.
- Wrap: tx_ts=0xFFFFFFF0, rx_ts=0x00000010 → `lat`=0x20. Short frame with tlast on beat 4 → no result, `cnt_frames`+1.
- Assert `reset` on beat 3 of a probe, deassert, continue driving beats through tlast → no `lat_valid`, `cnt_match`=0, `cnt_frames`=1. A following probe is measured correctly.

Source files
------------

// File: rtl/eth_ts_pkg.sv
// eth_ts_pkg: probe frame layout, constants and helpers shared by eth_send and eth_recv.
package eth_ts_pkg;
  localparam logic [15:0] UDP_PORT_DEF = 16'h0D80;
  localparam logic [15:0] MAGIC_DEF = 16'h5453;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_VER_IHL = 8'h45;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;
  localparam int SEQ_W = 32;
  localparam int TS_W = 32;
  localparam int OFF_ETYPE = 12;
  localparam int OFF_VIHL = 14;
  localparam int OFF_PROTO = 23;
  localparam int OFF_DPORT = 36;
  localparam int OFF_MAGIC = 42;
  localparam int OFF_SEQ = 44;
  localparam int OFF_TXTS = 48;
  localparam logic [2:0] BEAT_ETYPE = 3'(OFF_ETYPE / 8);
  localparam logic [2:0] BEAT_VIHL = 3'(OFF_VIHL / 8);
  localparam logic [2:0] BEAT_PROTO = 3'(OFF_PROTO / 8);
  localparam logic [2:0] BEAT_DPORT = 3'(OFF_DPORT / 8);
  localparam logic [2:0] BEAT_MAGIC = 3'(OFF_MAGIC / 8);
  localparam logic [2:0] BEAT_SEQ = 3'(OFF_SEQ / 8);
  localparam logic [2:0] BEAT_TXTS = 3'(OFF_TXTS / 8);
  localparam int LANE_ETYPE = OFF_ETYPE % 8;
  localparam int LANE_VIHL = OFF_VIHL % 8;
  localparam int LANE_PROTO = OFF_PROTO % 8;
  localparam int LANE_DPORT = OFF_DPORT % 8;
  localparam int LANE_MAGIC = OFF_MAGIC % 8;
  localparam int LANE_SEQ = OFF_SEQ % 8;
  localparam int LANE_TXTS = OFF_TXTS % 8;
  typedef enum logic [1:0] {S_SOF, S_HDR, S_TAIL} rx_state_t;
  // tdata lane 0 is the first wire byte, fields are big-endian on the wire
  function automatic logic [7:0] byte_at(input logic [63:0] d, input int lane);
    return d[lane*8 +: 8];
  endfunction
  function automatic logic [15:0] be16(input logic [63:0] d, input int lane);
    return {d[lane*8 +: 8], d[lane*8+8 +: 8]};
  endfunction
  function automatic logic [31:0] be32(input logic [63:0] d, input int lane);
    return {d[lane*8 +: 8], d[lane*8+8 +: 8], d[lane*8+16 +: 8], d[lane*8+24 +: 8]};
  endfunction
endpackage

// File: rtl/eth_recv_if.sv
// eth_recv_if: 64-bit MAC RX AXI-Stream (no tready).
interface eth_recv_if;
  logic m_axis_rx_tvalid;
  logic [63:0] m_axis_rx_tdata;
  logic [7:0] m_axis_rx_tkeep;
  logic m_axis_rx_tlast;
  logic m_axis_rx_tuser;
  modport master (output m_axis_rx_tvalid, m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tuser);
  modport slave (input m_axis_rx_tvalid, m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tuser);
endinterface

// File: rtl/eth_rx_stats.sv
// eth_rx_stats: wrapping 32-bit frame/match/error counters.
module eth_rx_stats (
  input  logic        clk156,
  input  logic        reset,
  input  logic        inc_frames,
  input  logic        inc_match,
  input  logic        inc_err,
  output logic [31:0] cnt_frames,
  output logic [31:0] cnt_match,
  output logic [31:0] cnt_err
);
  logic [31:0] frames_q, frames_d, match_q, match_d, err_q, err_d;
  always_comb begin
    frames_d = frames_q + 32'(inc_frames);
    match_d = match_q + 32'(inc_match);
    err_d = err_q + 32'(inc_err);
  end
  always_ff @(posedge clk156) begin
    if (reset) begin
      frames_q <= '0;
      match_q <= '0;
      err_q <= '0;
    end else begin
      frames_q <= frames_d;
      match_q <= match_d;
      err_q <= err_d;
    end
  end
  assign cnt_frames = frames_q;
  assign cnt_match = match_q;
  assign cnt_err = err_q;
endmodule

// File: rtl/eth_recv.sv
// eth_recv: parses UDP timestamp probes from MAC RX and reports latency plus frame stats.
module eth_recv import eth_ts_pkg::*; #(
  parameter logic [15:0] UDP_PORT = UDP_PORT_DEF,
  parameter logic [15:0] MAGIC = MAGIC_DEF
) (
  input  logic          clk156,
  input  logic          reset,
  input  logic [TS_W-1:0] ts_now,
  eth_recv_if.slave     rx,
  output logic          lat_valid,
  output logic [31:0]   lat,
  output logic [31:0]   lat_seq,
  output logic [31:0]   cnt_frames,
  output logic [31:0]   cnt_match,
  output logic [31:0]   cnt_err
);
  rx_state_t state_q, state_d;
  logic [2:0] beat_q, beat_d;
  logic ok_q, ok_d, elig_q, elig_d, lat_valid_q, lat_valid_d;
  logic [TS_W-1:0] rx_ts_q, rx_ts_d, tx_ts_q, tx_ts_d, lat_q, lat_d;
  logic [SEQ_W-1:0] seq_q, seq_d, lat_seq_q, lat_seq_d;
  logic sof, hdr, last, fail, match;
  logic [63:0] d;
  logic unused_keep;
  assign unused_keep = ^rx.m_axis_rx_tkeep[7:4];
  always_comb begin
    d = rx.m_axis_rx_tdata;
    sof = state_q == S_SOF && rx.m_axis_rx_tvalid;
    hdr = state_q == S_HDR && rx.m_axis_rx_tvalid;
    last = rx.m_axis_rx_tvalid && rx.m_axis_rx_tlast;
    fail = (beat_q == BEAT_ETYPE && be16(d, LANE_ETYPE) != ETHERTYPE_IPV4)
        || (beat_q == BEAT_VIHL && byte_at(d, LANE_VIHL) != IP_VER_IHL)
        || (beat_q == BEAT_PROTO && byte_at(d, LANE_PROTO) != IP_PROTO_UDP)
        || (beat_q == BEAT_DPORT && be16(d, LANE_DPORT) != UDP_PORT)
        || (beat_q == BEAT_MAGIC && be16(d, LANE_MAGIC) != MAGIC);
    rx_ts_d = sof ? ts_now : rx_ts_q;
    beat_d = sof ? 3'd1 : (hdr && beat_q != 3'd7) ? beat_q + 3'd1 : beat_q;
    ok_d = sof ? 1'b1 : ok_q && !(hdr && fail);
    seq_d = (hdr && beat_q == BEAT_SEQ) ? be32(d, LANE_SEQ) : seq_q;
    tx_ts_d = (hdr && beat_q == BEAT_TXTS) ? be32(d, LANE_TXTS) : tx_ts_q;
    // the timestamp beat qualifies the frame only if all four tx_ts bytes arrived
    elig_d = sof ? 1'b0
           : (hdr && beat_q == BEAT_TXTS) ? (!rx.m_axis_rx_tlast || &rx.m_axis_rx_tkeep[3:0])
           : elig_q;
    state_d = sof ? (rx.m_axis_rx_tlast ? S_SOF : S_HDR)
            : hdr ? (rx.m_axis_rx_tlast ? S_SOF : beat_q == BEAT_TXTS ? S_TAIL : S_HDR)
            : (state_q == S_TAIL && last) ? S_SOF : state_q;
    match = last && rx.m_axis_rx_tuser && elig_d && ok_d;
    lat_valid_d = match;
    lat_d = match ? rx_ts_d - tx_ts_d : lat_q;
    lat_seq_d = match ? seq_d : lat_seq_q;
  end
  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q <= S_SOF;
      beat_q <= '0;
      ok_q <= 1'b0;
      elig_q <= 1'b0;
      rx_ts_q <= '0;
      tx_ts_q <= '0;
      seq_q <= '0;
      lat_valid_q <= 1'b0;
      lat_q <= '0;
      lat_seq_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      ok_q <= ok_d;
      elig_q <= elig_d;
      rx_ts_q <= rx_ts_d;
      tx_ts_q <= tx_ts_d;
      seq_q <= seq_d;
      lat_valid_q <= lat_valid_d;
      lat_q <= lat_d;
      lat_seq_q <= lat_seq_d;
    end
  end
  eth_rx_stats u_stats (
    .clk156     (clk156),
    .reset      (reset),
    .inc_frames (last),
    .inc_match  (match),
    .inc_err    (last && !rx.m_axis_rx_tuser),
    .cnt_frames (cnt_frames),
    .cnt_match  (cnt_match),
    .cnt_err    (cnt_err)
  );
  assign lat_valid = lat_valid_q;
  assign lat = lat_q;
  assign lat_seq = lat_seq_q;
endmodule

// File: tb/tb_eth_recv.sv
// tb_eth_recv: scoreboard bench for eth_recv probe parsing, latency and counters.
module tb_eth_recv;
  logic clk156 = 1'b0;
  logic reset = 1'b1;
  logic [31:0] ts_now = '0;
  logic lat_valid;
  logic [31:0] lat, lat_seq, cnt_frames, cnt_match, cnt_err;
  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];
  logic prev_valid = 1'b0;
  eth_recv_if rx_if ();
  eth_recv dut (
    .clk156     (clk156),
    .reset      (reset),
    .ts_now     (ts_now),
    .rx         (rx_if.slave),
    .lat_valid  (lat_valid),
    .lat        (lat),
    .lat_seq    (lat_seq),
    .cnt_frames (cnt_frames),
    .cnt_match  (cnt_match),
    .cnt_err    (cnt_err)
  );
  always #5 clk156 = ~clk156;
  // scoreboard entries are {seq, expected latency}
  always @(negedge clk156) begin
    if (lat_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got seq=%h lat=%h, required no result", lat_seq, lat);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({lat_seq, lat} !== e) begin
          failures++;
          $display("FAIL result got seq=%h lat=%h, required seq=%h lat=%h", lat_seq, lat, e[63:32], e[31:0]);
        end
      end
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL pulse_width lat_valid high 2 cycles, required 1");
      end
    end
    prev_valid = lat_valid;
  end
  task automatic tick();
    @(posedge clk156);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    rx_if.m_axis_rx_tvalid = 1'b0;
    rx_if.m_axis_rx_tlast = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask
  task automatic send_frame(input logic [15:0] etype, input logic [15:0] dport, input logic [15:0] magic,
                            input logic [31:0] seq, input logic [31:0] tx, input logic [31:0] rxts,
                            input int nbeats, input logic [7:0] keep, input logic fcs_ok,
                            input bit gaps, input int rst_at);
    logic [7:0] by [64];
    logic [63:0] w;
    for (int i = 0; i < 64; i++) by[i] = 8'(i * 3 + 1);
    {by[12], by[13]} = etype;
    by[14] = 8'h45;
    by[23] = 8'h11;
    {by[36], by[37]} = dport;
    {by[42], by[43]} = magic;
    {by[44], by[45], by[46], by[47]} = seq;
    {by[48], by[49], by[50], by[51]} = tx;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && b > 0) begin
        int n;
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) begin
          rx_if.m_axis_rx_tvalid = 1'b0;
          ts_now = ts_now + 32'd3;
          tick();
        end
      end
      for (int k = 0; k < 8; k++) w[k*8 +: 8] = by[b*8 + k];
      rx_if.m_axis_rx_tvalid = 1'b1;
      rx_if.m_axis_rx_tdata = w;
      rx_if.m_axis_rx_tlast = (b == nbeats - 1);
      rx_if.m_axis_rx_tkeep = (b == nbeats - 1) ? keep : 8'hFF;
      rx_if.m_axis_rx_tuser = (b == nbeats - 1) ? fcs_ok : 1'b0;
      ts_now = (b == 0) ? rxts : rxts + 32'h55 + 32'(b);
      reset = (b == rst_at);
      tick();
    end
    rx_if.m_axis_rx_tvalid = 1'b0;
    rx_if.m_axis_rx_tlast = 1'b0;
    reset = 1'b0;
  endtask
  task automatic expect_counts(input string name, input logic [31:0] f, input logic [31:0] m, input logic [31:0] e);
    checks++;
    if ({cnt_frames, cnt_match, cnt_err} !== {f, m, e}) begin
      failures++;
      $display("FAIL %s counters got frames=%0d match=%0d err=%0d, required %0d/%0d/%0d",
               name, cnt_frames, cnt_match, cnt_err, f, m, e);
    end
  endtask
  task automatic test_reset();
    rx_if.m_axis_rx_tvalid = 1'b0;
    rx_if.m_axis_rx_tdata = '0;
    rx_if.m_axis_rx_tkeep = '0;
    rx_if.m_axis_rx_tlast = 1'b0;
    rx_if.m_axis_rx_tuser = 1'b0;
    do_reset();
    checks++;
    if ({lat_valid, lat, lat_seq} !== 65'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b lat=%h seq=%h, required 0/0/0", lat_valid, lat, lat_seq);
    end
    expect_counts("reset", 0, 0, 0);
  endtask
  task automatic test_probe();
    do_reset();
    sb.push_back({32'd5, 32'h180 - 32'h100});
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'd5, 32'h100, 32'h180, 8, 8'hFF, 1'b1, 1'b0, -1);
    checks++;
    if ({lat_valid, lat, lat_seq} !== {1'b1, 32'h80, 32'd5}) begin
      failures++;
      $display("FAIL probe_result got valid=%b lat=%h seq=%h, required 1/80/5", lat_valid, lat, lat_seq);
    end
    expect_counts("probe", 1, 1, 0);
    tick();
    checks++;
    if ({lat_valid, lat} !== {1'b0, 32'h80}) begin
      failures++;
      $display("FAIL probe_hold got valid=%b lat=%h, required 0/80", lat_valid, lat);
    end
  endtask
  task automatic test_bad_fcs();
    do_reset();
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'd5, 32'h100, 32'h180, 8, 8'hFF, 1'b0, 1'b0, -1);
    checks++;
    if (lat_valid !== 1'b0) begin
      failures++;
      $display("FAIL bad_fcs_valid got %b, required 0", lat_valid);
    end
    expect_counts("bad_fcs", 1, 0, 1);
  endtask
  task automatic test_filter();
    do_reset();
    send_frame(16'h0800, 16'h0D81, 16'h5453, 32'd6, 32'h100, 32'h180, 8, 8'hFF, 1'b1, 1'b0, -1);
    send_frame(16'h86DD, 16'h0D80, 16'h5453, 32'd7, 32'h100, 32'h180, 8, 8'hFF, 1'b1, 1'b0, -1);
    send_frame(16'h0800, 16'h0D80, 16'h0000, 32'd8, 32'h100, 32'h180, 8, 8'hFF, 1'b1, 1'b0, -1);
    repeat (2) tick();
    expect_counts("filter", 3, 0, 0);
  endtask
  task automatic test_back_to_back();
    do_reset();
    sb.push_back({32'h11, 32'h2000 - 32'h1234});
    sb.push_back({32'h12, 32'h3000 - 32'h2abc});
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'h11, 32'h1234, 32'h2000, 8, 8'hFF, 1'b1, 1'b1, -1);
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'h12, 32'h2abc, 32'h3000, 8, 8'h0F, 1'b1, 1'b1, -1);
    repeat (3) tick();
    expect_counts("back_to_back", 2, 2, 0);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL back_to_back_pending got %0d results missing, required 0", sb.size());
    end
  endtask
  task automatic test_wrap_short();
    do_reset();
    sb.push_back({32'd9, 32'h20});
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'd9, 32'hFFFFFFF0, 32'h00000010, 8, 8'hFF, 1'b1, 1'b0, -1);
    tick();
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'd10, 32'h100, 32'h180, 5, 8'hFF, 1'b1, 1'b0, -1);
    repeat (2) tick();
    checks++;
    if (lat !== 32'h20) begin
      failures++;
      $display("FAIL wrap_lat got %h, required 00000020", lat);
    end
    expect_counts("wrap_short", 2, 1, 0);
    sb.push_back({32'd11, 32'h500 - 32'h4F0});
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'd11, 32'h4F0, 32'h500, 7, 8'h0F, 1'b1, 1'b0, -1);
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'd12, 32'h4F0, 32'h500, 7, 8'h07, 1'b1, 1'b0, -1);
    repeat (2) tick();
    expect_counts("beat6_end", 4, 2, 0);
  endtask
  task automatic test_reset_mid();
    do_reset();
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'd20, 32'h100, 32'h180, 8, 8'hFF, 1'b1, 1'b0, 3);
    repeat (2) tick();
    expect_counts("reset_mid", 1, 0, 0);
    sb.push_back({32'd21, 32'h777 - 32'h700});
    send_frame(16'h0800, 16'h0D80, 16'h5453, 32'd21, 32'h700, 32'h777, 8, 8'hFF, 1'b1, 1'b0, -1);
    checks++;
    if ({lat_valid, lat, lat_seq} !== {1'b1, 32'h77, 32'd21}) begin
      failures++;
      $display("FAIL reset_mid_next got valid=%b lat=%h seq=%h, required 1/77/15", lat_valid, lat, lat_seq);
    end
    repeat (2) tick();
    expect_counts("reset_mid_next", 2, 1, 0);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL final_pending got %0d results missing, required 0", sb.size());
    end
  endtask
  initial begin
    test_reset();
    test_probe();
    test_bad_fcs();
    test_filter();
    test_back_to_back();
    test_wrap_short();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
